// File: rtl/video_stream_in.sv
// AXI4-Stream video ingress: re-quantizes 8-bit channels to 16-bit features,
// tracks frame geometry and buffers packed words in an FWFT FIFO.

module video_quant_ch (
  input  logic [7:0]  pix,
  input  logic [3:0]  q,
  output logic [15:0] d
);
  always_comb begin
    d = '0;
    if (q >= 4'd1 && q <= 4'd8) d = {8'd0, pix >> (4'd8 - q)};
  end
endmodule

module video_stream_in #(
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 3
) (
  input  logic        system_clk,
  input  logic        rst_n,
  input  logic        video_input_req,
  input  logic [3:0]  fea_in_quant_size,
  input  logic [9:0]  video_col_size,
  input  logic [9:0]  video_row_size,
  input  logic        axi_stream_tvalid,
  input  logic [31:0] axi_stream_tdata,
  input  logic [3:0]  axi_stream_tkeep,
  input  logic        axi_stream_tlast,
  input  logic        axi_stream_tuser,
  output logic        axi_stream_tready,
  output logic        video_valid,
  output logic [47:0] video_data,
  input  logic        video_ready,
  output logic        frame_done,
  output logic        err_line,
  output logic        err_sof
);
  localparam int NUM_CH = 3;
  localparam int CH_W   = 16;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;
  state_t state, state_nx;

  logic [3:0]  q_r;
  logic [9:0]  ncol, nrow, col, row, cur_col, cur_row;
  logic        acc, fwd, eol, last_pix, almost_full;
  logic [NUM_CH*CH_W-1:0] quant;
  logic        s1_vld, s1_last;
  logic [47:0] s1_data;
  logic [47:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic        wr, rd;
  logic        unused;

  assign unused = ^{axi_stream_tkeep, axi_stream_tdata[31:24]};

  assign almost_full = (CW'(FIFO_DEPTH) - count) <= CW'(AF_MARGIN);
  assign axi_stream_tready = (state == WAIT_SOF) | ((state == ACTIVE) & ~almost_full);
  assign acc = axi_stream_tvalid & axi_stream_tready;
  // Pre-SOF beats are swallowed; once active everything is forwarded.
  assign fwd = acc & ((state == ACTIVE) | axi_stream_tuser);

  // An SOF beat is always pixel (0,0), whatever the counters say.
  assign cur_col  = axi_stream_tuser ? '0 : col;
  assign cur_row  = axi_stream_tuser ? '0 : row;
  assign eol      = (cur_col == ncol - 10'd1);
  assign last_pix = eol & (cur_row == nrow - 10'd1);

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (video_input_req) state_nx = WAIT_SOF;
      WAIT_SOF: if (fwd) state_nx = last_pix ? IDLE : ACTIVE;
      ACTIVE:   if (fwd & last_pix) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0; ncol <= '0; nrow <= '0; col <= '0; row <= '0;
      err_line <= 1'b0; err_sof <= 1'b0;
    end else if (state == IDLE && video_input_req) begin
      q_r  <= fea_in_quant_size;
      ncol <= video_col_size;
      nrow <= video_row_size;
      col  <= '0;
      row  <= '0;
      err_line <= 1'b0;
      err_sof  <= 1'b0;
    end else if (fwd) begin
      col <= eol ? '0 : cur_col + 10'd1;
      row <= eol ? cur_row + 10'd1 : cur_row;
      if (axi_stream_tlast != eol) err_line <= 1'b1;
      if (state == ACTIVE && axi_stream_tuser && (col != '0 || row != '0)) err_sof <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    video_quant_ch u_quant (
      .pix (axi_stream_tdata[23-8*g -: 8]),
      .q   (q_r),
      .d   (quant[CH_W*g +: CH_W])
    );
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld  <= fwd;
      s1_last <= fwd & last_pix;
      if (fwd) s1_data <= quant;
    end
  end

  assign frame_done = s1_vld & s1_last;

  assign wr          = s1_vld;
  assign video_valid = (count != '0);
  assign rd          = video_valid & video_ready;
  assign video_data  = mem[rptr];

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= s1_data;
        wptr      <= wptr + 1'b1;
      end
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge system_clk) disable iff (!rst_n)
    !(wr && !rd && count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_video_stream_in.sv
// Scoreboard bench for video_stream_in: a frame-level model predicts words,
// frame_done timing and error flags from the accepted beats.

module tb_video_stream_in;
  localparam int FIFO_DEPTH = 16;
  localparam int AF_MARGIN  = 3;

  logic        system_clk = 0, rst_n = 0, video_input_req = 0;
  logic [3:0]  fea = 0;
  logic [9:0]  col_sz = 0, row_sz = 0;
  logic        tvalid = 0, tlast = 0, tuser = 0;
  logic [31:0] tdata = 0;
  logic [3:0]  tkeep = 4'hF;
  logic        tready, video_valid, video_ready = 0, frame_done, err_line, err_sof;
  logic [47:0] video_data;

  video_stream_in #(.FIFO_DEPTH(FIFO_DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .system_clk(system_clk), .rst_n(rst_n), .video_input_req(video_input_req),
    .fea_in_quant_size(fea), .video_col_size(col_sz), .video_row_size(row_sz),
    .axi_stream_tvalid(tvalid), .axi_stream_tdata(tdata), .axi_stream_tkeep(tkeep),
    .axi_stream_tlast(tlast), .axi_stream_tuser(tuser), .axi_stream_tready(tready),
    .video_valid(video_valid), .video_data(video_data), .video_ready(video_ready),
    .frame_done(frame_done), .err_line(err_line), .err_sof(err_sof));

  always #5 system_clk = ~system_clk;

  int tests = 0, fails = 0, done_cnt = 0, rdy_mode = 1;
  bit gaps = 0;
  longint cyc = 0, exp_done = -1;

  always @(posedge system_clk) cyc++;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] qf(int p, int q);
    if (q >= 1 && q <= 8) return 16'(p / (1 << (8 - q)));
    return 16'd0;
  endfunction

  // Reference model: linear pixel index within the frame, 0..M*N-1.
  logic [47:0] exp_q[$];
  int  m_st = 0, m_pos = 0, m_n = 1, m_m = 1, m_q = 0;
  bit  m_eline = 0, m_esof = 0;

  always @(negedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; exp_q.delete(); m_eline = 0; m_esof = 0; exp_done = -1;
    end else if (m_st == 0 && video_input_req) begin
      m_st = 1; m_q = fea; m_n = col_sz; m_m = row_sz; m_eline = 0; m_esof = 0;
    end else if (m_st != 0 && tvalid && tready && (m_st == 2 || tuser)) begin
      if (tuser) begin
        if (m_st == 2) m_esof = 1;
        m_pos = 0;
      end
      m_st = 2;
      if (tlast != ((m_pos % m_n) == m_n - 1)) m_eline = 1;
      exp_q.push_back({qf(tdata[7:0], m_q), qf(tdata[15:8], m_q), qf(tdata[23:16], m_q)});
      m_pos++;
      if (m_pos == m_n * m_m) begin
        m_st = 0;
        exp_done = cyc + 1;
      end
    end
  end

  always @(negedge system_clk) begin
    if (rst_n && video_valid && video_ready) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("video_data", video_data, exp_q.pop_front());
    end
  end

  always @(negedge system_clk) begin
    if (rst_n && (frame_done || cyc == exp_done)) chk("frame_done", frame_done, cyc == exp_done);
    if (rst_n && frame_done) done_cnt++;
  end

  initial forever begin
    @(posedge system_clk); #1;
    video_ready = (rdy_mode == 2) ? 1'($urandom_range(1)) : rdy_mode[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_req(int q, int n, int m);
    fea = 4'(q); col_sz = 10'(n); row_sz = 10'(m);
    video_input_req = 1;
    @(posedge system_clk); #1;
    video_input_req = 0;
  endtask

  task automatic send(logic [31:0] d, bit u, bit l);
    int t = 0;
    if (gaps && $urandom_range(3) == 0) begin @(posedge system_clk); #1; end
    tvalid = 1; tdata = d; tuser = u; tlast = l;
    @(negedge system_clk);
    while (!tready && t < 300) begin @(negedge system_clk); t++; end
    if (!tready) chk("tready_timeout", 0, 1);
    @(posedge system_clk); #1;
    tvalid = 0; tuser = 0; tlast = 0;
  endtask

  task automatic send_frame(int n, int m, int junk, int bad_last, int sof_at, int limit,
                            bit fixed, logic [31:0] fd);
    int total, pp;
    total = (sof_at >= 0) ? sof_at + n * m : n * m;
    for (int j = 0; j < junk; j++) send($urandom, 0, 1'($urandom_range(1)));
    for (int b = 0; b < total && b < limit; b++) begin
      pp = (sof_at >= 0 && b >= sof_at) ? b - sof_at : b;
      send(fixed ? fd : $urandom, (b == 0) || (b == sof_at), ((pp % n) == n - 1) ^ (b == bad_last));
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(posedge system_clk); #1; t++; end
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge system_clk);
    #1;
  endtask

  int dc0, n, m;

  initial begin
    repeat (2) @(posedge system_clk);
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_valid", video_valid, 0);
    chk("rst_data", video_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err_line", err_line, 0);
    chk("rst_err_sof", err_sof, 0);
    rst_n = 1;
    @(posedge system_clk); #1;

    // 4x2 constant frame, q=8
    rdy_mode = 1; gaps = 0; dc0 = done_cnt;
    do_req(8, 4, 2);
    send_frame(4, 2, 0, -1, -1, 1000, 1, 32'h00AABBCC);
    drain();
    chk("t1_done_cnt", done_cnt - dc0, 1);
    chk("t1_err_line", err_line, 0);
    chk("t1_err_sof", err_sof, 0);

    // single-pixel frame: latency and q=4 values
    do_req(4, 1, 1);
    tvalid = 1; tdata = 32'h00F08010; tuser = 1; tlast = 1;
    @(negedge system_clk);
    chk("t2_tready", tready, 1);
    @(posedge system_clk); #1;
    tvalid = 0; tuser = 0; tlast = 0;
    @(negedge system_clk);
    chk("t2_done_pulse", frame_done, 1);
    chk("t2_valid_early", video_valid, 0);
    chk("t2_idle_tready", tready, 0);
    @(negedge system_clk);
    chk("t2_valid", video_valid, 1);
    chk("t2_data", video_data, 48'h0001_0008_000F);
    @(posedge system_clk); #1;
    drain();

    // q=0, and a req pulse mid-frame that must be ignored
    do_req(0, 3, 2);
    fork
      send_frame(3, 2, 0, -1, -1, 1000, 0, 0);
      begin repeat (3) @(posedge system_clk); #1; do_req(2, 7, 7); end
    join
    drain();
    chk("t3_not_rearmed", tready, 0);

    // junk before SOF, random ready
    rdy_mode = 2; gaps = 1; dc0 = done_cnt;
    do_req(6, 5, 3);
    send_frame(5, 3, 3, -1, -1, 1000, 0, 0);
    drain();
    chk("t4_done_cnt", done_cnt - dc0, 1);
    chk("t4_err_line", err_line, 0);

    // backpressure
    rdy_mode = 0; gaps = 0;
    do_req(7, 4, 5);
    fork
      send_frame(4, 5, 0, -1, -1, 1000, 0, 0);
      begin
        repeat (40) @(posedge system_clk);
        #2;
        chk("t5_tready_low", tready, 0);
        chk("t5_valid", video_valid, 1);
        chk("t5_fill_lo", exp_q.size() >= FIFO_DEPTH - AF_MARGIN, 1);
        chk("t5_fill_hi", exp_q.size() <= FIFO_DEPTH, 1);
        rdy_mode = 1;
      end
    join
    drain();

    // tlast on 3rd beat of a 4-wide line
    dc0 = done_cnt;
    do_req(8, 4, 2);
    send_frame(4, 2, 0, 2, -1, 1000, 0, 0);
    drain();
    chk("t6_err_line", err_line, 1);
    chk("t6_err_sof", err_sof, 0);
    chk("t6_done_cnt", done_cnt - dc0, 1);
    repeat (3) @(posedge system_clk);
    #1;
    chk("t6_err_sticky", err_line, 1);

    // tuser on beat 5 of a 4x2 frame
    dc0 = done_cnt;
    do_req(5, 4, 2);
    send_frame(4, 2, 0, -1, 4, 1000, 0, 0);
    drain();
    chk("t7_err_sof", err_sof, 1);
    chk("t7_err_line", err_line, 0);
    chk("t7_done_cnt", done_cnt - dc0, 1);

    // randomized frames, including N=1 and out-of-range q
    rdy_mode = 2; gaps = 1;
    for (int i = 0; i < 5; i++) begin
      n = (i == 0) ? 1 : $urandom_range(1, 6);
      m = $urandom_range(1, 4);
      dc0 = done_cnt;
      do_req((i == 1) ? 12 : $urandom_range(15), n, m);
      chk("t8_err_cleared", {err_line, err_sof}, 0);
      send_frame(n, m, $urandom_range(2), -1, -1, 1000, 0, 0);
      drain();
      chk("t8_done_cnt", done_cnt - dc0, 1);
      chk("t8_err_line", err_line, m_eline);
      chk("t8_err_sof", err_sof, m_esof);
    end

    // asynchronous reset mid-frame
    rdy_mode = 0; gaps = 0;
    do_req(8, 4, 4);
    send_frame(4, 4, 0, 1, -1, 6, 0, 0);
    repeat (3) @(posedge system_clk);
    #1;
    chk("t9_pre_err_line", err_line, 1);
    chk("t9_pre_valid", video_valid, 1);
    chk("t9_pre_tready", tready, 1);
    @(posedge system_clk); #3;
    rst_n = 0;
    #1;
    chk("t9_tready", tready, 0);
    chk("t9_valid", video_valid, 0);
    chk("t9_data", video_data, 0);
    chk("t9_done", frame_done, 0);
    chk("t9_err_line", err_line, 0);
    chk("t9_err_sof", err_sof, 0);
    @(posedge system_clk); #1;
    rst_n = 1;
    rdy_mode = 1;
    @(posedge system_clk); #1;

    // recovery frame
    dc0 = done_cnt;
    do_req(3, 3, 3);
    send_frame(3, 3, 1, -1, -1, 1000, 0, 0);
    drain();
    chk("t10_done_cnt", done_cnt - dc0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/video_stream_in.md
Name: video_stream_in

Overview:
- AXI4-Stream video ingress for the accelerator; the input-side counterpart of the video output path.
- Accepts 32-bit pixel beats (tuser = start of frame, tlast = end of line) from the camera/DMA side.
- Re-quantizes each 8-bit channel to a 16-bit fixed-point feature value, packs three channels into 48 bits and buffers them.
- Presents the result to the feature loader over a valid/ready handshake, frame-gated by a per-frame request.

Parameters:
- FIFO_DEPTH, 16, entries in the internal 48-bit output buffer; power of two, >=8.
- AF_MARGIN, 3, tready drops when free entries <= AF_MARGIN, covering in-flight beats.

Ports:
- system_clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- video_input_req  input  1  one-cycle pulse arming capture of the next frame
- fea_in_quant_size  input  4  fractional bits q of the feature format, valid 1..8
- video_col_size  input  10  pixels per line, N>=1
- video_row_size  input  10  lines per frame, M>=1
- axi_stream_tvalid  input  1  slave beat valid
- axi_stream_tdata  input  32  {pad[31:24], c0[23:16], c1[15:8], c2[7:0]}
- axi_stream_tkeep  input  4  ignored
- axi_stream_tlast  input  1  end of line
- axi_stream_tuser  input  1  start of frame
- axi_stream_tready  output  1  slave ready
- video_valid  output  1  packed feature word valid
- video_data  output  48  {ch2[47:32], ch1[31:16], ch0[15:0]}
- video_ready  input  1  downstream accepts word
- frame_done  output  1  one-cycle pulse when the last pixel of the frame is written to the buffer
- err_line  output  1  sticky: tlast position mismatched the column count
- err_sof  output  1  sticky: tuser seen mid-frame

Behaviour:
- Reset values:
  - tready=0, video_valid=0, video_data=0, frame_done=0, err_line=0, err_sof=0.
  - FSM=IDLE; counters and buffer cleared.
- A beat is accepted when tvalid & tready.
- FSM states:
  - IDLE: tready=0. video_input_req -> WAIT_SOF; clear err flags and counters.
  - WAIT_SOF: tready=1. Beats with tuser=0 are accepted and discarded. An accepted beat with tuser=1 is pixel (0,0) and forwards -> ACTIVE.
  - ACTIVE: tready = ~almost_full. Every accepted beat is forwarded. col increments; at col==N-1 it wraps to 0 and row increments. Pixel (M-1,N-1) pulses frame_done on its buffer-write cycle -> IDLE.
- video_input_req in non-IDLE states is ignored.
- Quantization, per channel p (8-bit unsigned):
  - q in 1..8: d = zero-extend16(p >> (8-q)).
  - q=0 or q>8: d=0.
  - Result is always non-negative, with no saturation needed.
- Channel mapping: ch0=tdata[23:16], ch1=tdata[15:8], ch2=tdata[7:0]; tdata[31:24] dropped.
- Pipeline:
  - One register stage (quantize) feeds a synchronous FWFT FIFO.
  - An accepted beat appears on video_valid exactly 2 cycles later when the buffer is empty.
  - video_data holds stable while video_valid & ~video_ready.
- Buffer: almost_full = (FIFO_DEPTH - count) <= AF_MARGIN. The buffer never overflows; an overflow write is a design bug, asserted in simulation.
- Simultaneous FIFO read and write at full or empty is legal; count is unchanged.
- tlast checks:
  - tlast=1 at col!=N-1, or tlast=0 at col==N-1: set err_line.
  - Counting continues by col_size; tlast is not used to resync.
- tuser=1 accepted in ACTIVE at a position other than (0,0):
  - set err_sof;
  - the beat becomes pixel (0,0); counters restart;
  - the frame continues and the beat is forwarded.
- N=1: every pixel ends a line. M=1,N=1: a single-beat frame pulses frame_done the cycle after the SOF beat.
- fea_in_quant_size, video_col_size and video_row_size are sampled on video_input_req and held for the frame.
- Asynchronous reset mid-frame: all state is cleared immediately, including buffered words, which are lost. tready drops in the same cycle.

Test Plan:
- Req, q=8, N=4, M=2, tdata=0x00AABBCC with tuser on the first beat and tlast every 4th -> 8 words of {0x00CC,0x00BB,0x00AA}; frame_done once, 1 cycle after the 8th beat; no errors.
- q=4, pixel 0x00F08010 -> video_data={0x0001,0x0008,0x000F}. q=0 -> all zero.
- Three tuser=0 beats before SOF in WAIT_SOF -> all accepted, none output; output starts at the SOF beat.
- video_ready held 0, FIFO_DEPTH=16, AF_MARGIN=3, continuous tvalid -> tready drops at count 13; no word lost; releasing ready drains in order.
- N=4, tlast on the 3rd beat -> err_line=1 and stays set; frame still completes after M*N beats.
- tuser on beat 5 of a 4x2 frame -> err_sof=1; frame_done after 8 beats counted from beat 5. rst_n pulsed mid-frame -> all outputs return to reset values asynchronously.
